// File: rtl/uart_tx_arbiter_if.sv
// Byte-producer and transmitter-side signals shared between the requesters and the UART arbiter.
// The producer side uses the master modport and the arbiter uses the slave modport.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic [ID_W-1:0]      grant_id;

    modport master (
        output req_valid, req_data,
        input  req_ready, tx_start, tx_data, tx_busy, grant_id
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx_start, tx_data, tx_busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers,
// pacing frames with its own guard counter instead of the transmitter's done flag.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int FRAME_CYCLES = 11
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(FRAME_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ISSUE, S_WAIT} state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_busy_q, tx_busy_d;

    logic [7:0]           byte_arr [NUM_REQ];
    logic [NUM_REQ-1:0]   above_ptr;
    logic [NUM_REQ-1:0]   hi_mask;
    logic [NUM_REQ-1:0]   pick;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [NUM_REQ-1:0]   id_bit_mask [ID_W];
    logic [ID_W-1:0]      winner;
    logic                 any_valid;
    logic                 grant_valid;

    // Requesters above the pointer win first; otherwise the search wraps to the lowest index.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign byte_arr[gi]  = bus.req_data[8*gi +: 8];
        assign above_ptr[gi] = (ID_W'(gi) > ptr_q);
        for (genvar gb = 0; gb < ID_W; gb++) begin : g_bit
            assign id_bit_mask[gb][gi] = ((gi >> gb) % 2 == 1) ? pick_onehot[gi] : 1'b0;
        end
    end

    for (genvar gi = 0; gi < ID_W; gi++) begin : g_enc
        assign winner[gi] = |id_bit_mask[gi];
    end

    assign hi_mask     = bus.req_valid & above_ptr;
    assign pick        = (|hi_mask) ? hi_mask : bus.req_valid;
    assign pick_onehot = pick & (~pick + NUM_REQ'(1));
    assign any_valid   = |bus.req_valid;
    assign grant_valid = bus.req_valid[grant_id_q];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            cnt_q       <= '0;
            grant_id_q  <= '0;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            grant_id_q  <= grant_id_d;
            req_ready_q <= req_ready_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            tx_busy_q   <= tx_busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  if (any_valid) state_d = S_GRANT;
            S_GRANT: begin
                // A requester that withdraws its byte loses the slot without moving the pointer.
                if (grant_valid) begin
                    state_d = S_ISSUE;
                    ptr_d   = grant_id_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = CNT_W'(FRAME_CYCLES - 1);
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_d = '0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        tx_busy_d   = tx_busy_q;
        grant_id_d  = grant_id_q;
        case (state_q)
            S_IDLE: begin
                tx_busy_d = 1'b0;
                if (any_valid) begin
                    req_ready_d = pick_onehot;
                    grant_id_d  = winner;
                    tx_busy_d   = 1'b1;
                end
            end
            S_GRANT: begin
                if (grant_valid) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = byte_arr[grant_id_q];
                end else begin
                    tx_busy_d = 1'b0;
                end
            end
            S_WAIT:  if (cnt_q == '0) tx_busy_d = 1'b0;
            default: ;
        endcase
    end

    assign bus.req_ready = req_ready_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_busy   = tx_busy_q;
    assign bus.grant_id  = grant_id_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed multi-frame sequences and a
// randomized run checked against a frame-schedule reference model.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int FC      = 11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .FRAME_CYCLES(FC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [31:0] data;
        int          cycles;
        logic [3:0]  e_ready;
        logic        e_start;
        logic [7:0]  e_data;
        logic        e_busy;
        logic [1:0]  e_gid;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_n  = 0;

    function automatic void add(logic rst_n, logic [3:0] valid, logic [31:0] data, int cycles,
                                logic [3:0] r, logic s, logic [7:0] d, logic b, logic [1:0] g);
        vec_t v;
        v.rst_n = rst_n; v.valid = valid; v.data = data; v.cycles = cycles;
        v.e_ready = r; v.e_start = s; v.e_data = d; v.e_busy = b; v.e_gid = g;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        edge_n++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] r, input logic s,
                           input logic [7:0] d, input logic b, input logic [1:0] g);
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'(r));
        chk({tag, ".start"}, 32'(bus.tx_start),  32'(s));
        chk({tag, ".data"},  32'(bus.tx_data),   32'(d));
        chk({tag, ".busy"},  32'(bus.tx_busy),   32'(b));
        chk({tag, ".gid"},   32'(bus.grant_id),  32'(g));
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        bus.req_valid = 4'b0000;
        bus.req_data  = 32'h0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Clocks until tx_start, flagging any ready pulse outside the allowed set.
    task automatic wait_start(input string tag, input logic [3:0] allowed, input int budget,
                              output int at_edge);
        at_edge = -1;
        for (int c = 0; c < budget; c++) begin
            step();
            if (bus.req_ready != 4'b0000)
                chk({tag, ".ready_allowed"}, 32'(bus.req_ready & ~allowed), 32'h0);
            if (bus.tx_start) begin
                at_edge = edge_n;
                break;
            end
        end
        if (at_edge < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.timeout: no tx_start within %0d cycles", tag, budget);
        end
    endtask

    // Round-robin rule: first valid requester searching upward from ptr+1, wrapping.
    function automatic int rr_pick(int ptr, logic [3:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (ptr + k) % NUM_REQ;
            if (((v >> idx) & 4'd1) != 4'd0) return idx;
        end
        return ptr;
    endfunction

    task automatic run_random(input int n_edges);
        logic [7:0] cur [NUM_REQ];
        int         gap [NUM_REQ];
        int         arb_edge, g_edge, g_w, m_ptr, n, w;
        logic [7:0] m_data, acc_byte;
        logic [1:0] m_gid;
        logic [3:0] v, e_ready;
        logic       e_start, e_busy;

        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            cur[i] = 8'($urandom);
            gap[i] = int'($urandom_range(0, 5));
        end
        arb_edge = edge_n + 1;
        g_edge   = -100;
        g_w      = 0;
        m_ptr    = NUM_REQ - 1;
        m_data   = 8'h00;
        acc_byte = 8'h00;
        m_gid    = 2'd0;

        for (int c = 0; c < n_edges; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.req_valid[i]       = (gap[i] == 0);
                bus.req_data[8*i +: 8] = cur[i];
            end
            v = bus.req_valid;
            step();
            n = edge_n;
            if (n == arb_edge) begin
                if (v != 4'b0000) begin
                    w        = rr_pick(m_ptr, v);
                    g_edge   = n;
                    g_w      = w;
                    m_gid    = 2'(w);
                    m_ptr    = w;
                    acc_byte = cur[w];
                    arb_edge = n + FC + 3;
                end else begin
                    arb_edge = n + 1;
                end
            end
            if (n == g_edge + 1) m_data = acc_byte;
            e_ready = (n == g_edge) ? 4'(1 << g_w) : 4'b0000;
            e_start = (n == g_edge + 1);
            e_busy  = (n >= g_edge) && (n <= g_edge + 1 + FC);
            chk_all("rnd", e_ready, e_start, m_data, e_busy, m_gid);

            for (int i = 0; i < NUM_REQ; i++)
                if (gap[i] > 0) gap[i]--;
            if (n == g_edge + 1) begin
                cur[g_w] = 8'($urandom);
                gap[g_w] = int'($urandom_range(0, 20));
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, prev;
        reset         = 1'b0;
        bus.req_valid = 4'b0000;
        bus.req_data  = 32'h0;

        // Reset, single request from 0, then a dropped grant for 1 and regrant order.
        add(1'b0, 4'b0000, 32'h0000_0000, 2,  4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        add(1'b1, 4'b0001, 32'h0000_0055, 1,  4'b0001, 1'b0, 8'h00, 1'b1, 2'd0);
        add(1'b1, 4'b0001, 32'h0000_0055, 1,  4'b0000, 1'b1, 8'h55, 1'b1, 2'd0);
        add(1'b1, 4'b0000, 32'h0000_0000, FC, 4'b0000, 1'b0, 8'h55, 1'b1, 2'd0);
        add(1'b1, 4'b0000, 32'h0000_0000, 1,  4'b0000, 1'b0, 8'h55, 1'b0, 2'd0);
        add(1'b1, 4'b0010, 32'h0000_3300, 1,  4'b0010, 1'b0, 8'h55, 1'b1, 2'd1);
        add(1'b1, 4'b0000, 32'h0000_3300, 1,  4'b0000, 1'b0, 8'h55, 1'b0, 2'd1);
        add(1'b1, 4'b0000, 32'h0000_0000, 1,  4'b0000, 1'b0, 8'h55, 1'b0, 2'd1);
        add(1'b1, 4'b0110, 32'h0022_3300, 1,  4'b0010, 1'b0, 8'h55, 1'b1, 2'd1);
        add(1'b1, 4'b0110, 32'h0022_3300, 1,  4'b0000, 1'b1, 8'h33, 1'b1, 2'd1);
        add(1'b1, 4'b0100, 32'h0022_0000, FC, 4'b0000, 1'b0, 8'h33, 1'b1, 2'd1);
        add(1'b1, 4'b0100, 32'h0022_0000, 1,  4'b0000, 1'b0, 8'h33, 1'b0, 2'd1);
        add(1'b1, 4'b0100, 32'h0022_0000, 1,  4'b0100, 1'b0, 8'h33, 1'b1, 2'd2);
        add(1'b1, 4'b0100, 32'h0022_0000, 1,  4'b0000, 1'b1, 8'h22, 1'b1, 2'd2);
        add(1'b1, 4'b0000, 32'h0000_0000, FC, 4'b0000, 1'b0, 8'h22, 1'b1, 2'd2);
        add(1'b1, 4'b0000, 32'h0000_0000, 1,  4'b0000, 1'b0, 8'h22, 1'b0, 2'd2);

        @(negedge clk);
        foreach (vecs[r]) begin
            reset         = vecs[r].rst_n;
            bus.req_valid = vecs[r].valid;
            bus.req_data  = vecs[r].data;
            for (int c = 0; c < vecs[r].cycles; c++) begin
                step();
                chk_all($sformatf("vec%0d", r), vecs[r].e_ready, vecs[r].e_start,
                        vecs[r].e_data, vecs[r].e_busy, vecs[r].e_gid);
            end
        end

        // All requesters valid: fair rotation, frames FC+3 cycles apart.
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'hA3A2_A1A0;
        prev = -1;
        for (int j = 0; j < 5; j++) begin
            wait_start("rot", 4'b1111, 40, e);
            if (e >= 0) begin
                chk($sformatf("rot%0d.data", j), 32'(bus.tx_data), 32'(8'hA0 + 8'(j % NUM_REQ)));
                if (prev >= 0) chk($sformatf("rot%0d.spacing", j), 32'(e - prev), 32'(FC + 3));
                prev = e;
            end
        end

        // After a grant to 2, requesters 0 and 2 valid: wrap past 3 to 0, then 2.
        do_reset();
        bus.req_valid = 4'b0100;
        bus.req_data  = 32'h0012_0010;
        wait_start("wrap_a", 4'b0100, 40, e);
        chk("wrap_a.data", 32'(bus.tx_data), 32'h12);
        bus.req_valid = 4'b0101;
        wait_start("wrap_b", 4'b0101, 40, e);
        chk("wrap_b.data", 32'(bus.tx_data), 32'h10);
        chk("wrap_b.gid", 32'(bus.grant_id), 32'd0);
        wait_start("wrap_c", 4'b0101, 40, e);
        chk("wrap_c.data", 32'(bus.tx_data), 32'h12);
        chk("wrap_c.gid", 32'(bus.grant_id), 32'd2);

        // Reset while the guard counter sits at 5 aborts the frame and restores priority to 0.
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'hA3A2_A1A0;
        wait_start("abort", 4'b1111, 40, e);
        chk("abort.first", 32'(bus.tx_data), 32'hA0);
        for (int k = 0; k < 6; k++) step();
        chk("abort.busy_before", 32'(bus.tx_busy), 32'd1);
        reset = 1'b0;
        step();
        chk_all("abort.rst", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        reset = 1'b1;
        step();
        chk_all("abort.regrant", 4'b0001, 1'b0, 8'h00, 1'b1, 2'd0);
        step();
        chk_all("abort.issue", 4'b0000, 1'b1, 8'hA0, 1'b1, 2'd0);

        // Only requester 3 valid: it is granted again every frame.
        do_reset();
        bus.req_valid = 4'b1000;
        for (int j = 1; j <= 3; j++) begin
            bus.req_data = {8'(j), 24'h0};
            wait_start($sformatf("solo%0d", j), 4'b1000, 40, e);
            chk($sformatf("solo%0d.data", j), 32'(bus.tx_data), 32'(j));
            chk($sformatf("solo%0d.gid", j), 32'(bus.grant_id), 32'd3);
        end
        bus.req_valid = 4'b0000;

        run_random(800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
